// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// hazard_pkg: scoreboard entry type and forwarding-select encoding
// shared by the hazard scoreboard, its match encoder and interface.
package hazard_pkg;

  localparam int REG_ADDRESS_WIDTH_DEF = 3;

  // Entries store the address at a fixed maximum width so the
  // struct type does not depend on a module parameter.
  localparam int DA_MAXW = 8;

  localparam int FSEL_RF = 0;

  typedef struct packed {
    logic               v;
    logic [DA_MAXW-1:0] DA;
    logic               ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// DOF-side bundle for the hazard scoreboard.
// master = ID/DOF stage driving requests, slave = scoreboard.
interface hazard_scoreboard_ctrl_if #(
  parameter int REG_ADDRESS_WIDTH = hazard_pkg::REG_ADDRESS_WIDTH_DEF,
  parameter int PIPE_DEPTH        = 3,
  parameter int CNT_WIDTH         = 16
);
  localparam int FSEL_WIDTH = $clog2(PIPE_DEPTH + 1);

  logic                         id_valid;
  logic [REG_ADDRESS_WIDTH-1:0] AA;
  logic [REG_ADDRESS_WIDTH-1:0] BA;
  logic                         MA;
  logic                         MB;
  logic                         id_RW;
  logic [REG_ADDRESS_WIDTH-1:0] id_DA;
  logic                         id_is_load;
  logic                         flush;
  logic                         stat_clr;
  logic                         DHS;
  logic [FSEL_WIDTH-1:0]        fwd_sel_a;
  logic [FSEL_WIDTH-1:0]        fwd_sel_b;
  logic [CNT_WIDTH-1:0]         stall_count;

  modport master (
    output id_valid, AA, BA, MA, MB,
    output id_RW, id_DA, id_is_load,
    output flush, stat_clr,
    input  DHS, fwd_sel_a, fwd_sel_b,
    input  stall_count
  );

  modport slave (
    input  id_valid, AA, BA, MA, MB,
    input  id_RW, id_DA, id_is_load,
    input  flush, stat_clr,
    output DHS, fwd_sel_a, fwd_sel_b,
    output stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_ctrl_match.sv
// hazard_match: youngest-first priority encoder of one source
// operand against the scoreboard (hit_o, idx_o, ld0_o).
module hazard_match
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int AW         = 3,
  parameter int IW         = 2
) (
  input  sb_entry_t [PIPE_DEPTH-1:0] sb_i,
  input  logic [AW-1:0]              addr_i,
  input  logic                       mux_i,
  output logic                       hit_o,
  output logic [IW-1:0]              idx_o,
  output logic                       ld0_o
);

  // Scan oldest to youngest; the last hit written wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    if (!mux_i && addr_i != '0) begin
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (sb_i[k].v &&
            sb_i[k].DA == DA_MAXW'(addr_i)) begin
          hit_o = 1'b1;
          idx_o = IW'(k);
        end
      end
    end
    ld0_o = hit_o && (idx_o == '0) && sb_i[0].ld;
  end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Multi-stage data-hazard scoreboard: stall, forwarding selects and
// saturating stall counter. Ports: clk, reset, bus (slave). Macro FORWARDING_EN.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDRESS_WIDTH = REG_ADDRESS_WIDTH_DEF,
  parameter int PIPE_DEPTH        = 3,
  parameter int CNT_WIDTH         = 16
) (
  input logic                     clk,
  input logic                     reset,
  hazard_scoreboard_ctrl_if.slave bus
);

  localparam int FSEL_WIDTH = $clog2(PIPE_DEPTH + 1);

  sb_entry_t [PIPE_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

  logic                  hit_a, hit_b;
  logic                  ld0_a, ld0_b;
  logic [FSEL_WIDTH-1:0] idx_a, idx_b;
  logic                  hz_a, hz_b;
  logic                  dhs;
  logic                  wr;
  logic [FSEL_WIDTH-1:0] fsel_a, fsel_b;

  hazard_match #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .AW        (REG_ADDRESS_WIDTH),
    .IW        (FSEL_WIDTH)
  ) u_match_a (
    .sb_i  (sb_q),
    .addr_i(bus.AA),
    .mux_i (bus.MA),
    .hit_o (hit_a),
    .idx_o (idx_a),
    .ld0_o (ld0_a)
  );

  hazard_match #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .AW        (REG_ADDRESS_WIDTH),
    .IW        (FSEL_WIDTH)
  ) u_match_b (
    .sb_i  (sb_q),
    .addr_i(bus.BA),
    .mux_i (bus.MB),
    .hit_o (hit_b),
    .idx_o (idx_b),
    .ld0_o (ld0_b)
  );

`ifdef FORWARDING_EN
  // Only a load result still in EX cannot be forwarded.
  assign hz_a = ld0_a;
  assign hz_b = ld0_b;
  assign fsel_a = (hit_a && !ld0_a && !reset)
                ? idx_a + FSEL_WIDTH'(1)
                : FSEL_WIDTH'(FSEL_RF);
  assign fsel_b = (hit_b && !ld0_b && !reset)
                ? idx_b + FSEL_WIDTH'(1)
                : FSEL_WIDTH'(FSEL_RF);
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx_a, idx_b, ld0_a, ld0_b};
  assign hz_a   = hit_a;
  assign hz_b   = hit_b;
  assign fsel_a = FSEL_WIDTH'(FSEL_RF);
  assign fsel_b = FSEL_WIDTH'(FSEL_RF);
`endif

  assign dhs = !reset && bus.id_valid && (hz_a || hz_b);

  // A stalled or flushed instruction leaves a bubble behind.
  assign wr = bus.id_valid && bus.id_RW &&
              (bus.id_DA != '0) && !dhs && !bus.flush;

  always_comb begin
    sb_d = sb_q;
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[0] = '0;
    if (wr) begin
      sb_d[0].v  = 1'b1;
      sb_d[0].DA = DA_MAXW'(bus.id_DA);
      sb_d[0].ld = bus.id_is_load;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.stat_clr) begin
      cnt_d = '0;
    end else if (dhs && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.DHS         = dhs;
  assign bus.fwd_sel_a   = fsel_a;
  assign bus.fwd_sel_b   = fsel_b;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl (PIPE_DEPTH=3, CNT_WIDTH=4).
// Expectations follow FORWARDING_EN when it is defined.
module tb_hazard_scoreboard_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  hazard_scoreboard_ctrl_if #(
    .REG_ADDRESS_WIDTH(3),
    .PIPE_DEPTH       (3),
    .CNT_WIDTH        (4)
  ) bus ();

  hazard_scoreboard_ctrl #(
    .REG_ADDRESS_WIDTH(3),
    .PIPE_DEPTH       (3),
    .CNT_WIDTH        (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic rw,
                        input logic [2:0] da, input logic ld,
                        input logic [2:0] aa, input logic ma,
                        input logic [2:0] ba, input logic mb,
                        input logic fl, input logic clr);
    bus.id_valid   = v;
    bus.id_RW      = rw;
    bus.id_DA      = da;
    bus.id_is_load = ld;
    bus.AA         = aa;
    bus.MA         = ma;
    bus.BA         = ba;
    bus.MB         = mb;
    bus.flush      = fl;
    bus.stat_clr   = clr;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    set_in(1, 1, 3, 0, 3, 0, 3, 0, 0, 0);
    neg; chk("rst_dhs0", bus.DHS, 0);
    chk("rst_fa0", bus.fwd_sel_a, 0);
    nxt;
    neg; chk("rst_dhs1", bus.DHS, 0);
    chk("rst_cnt", bus.stall_count, 0);
    nxt;
    reset = 1'b0;

    set_in(1, 0, 0, 0, 3, 0, 3, 0, 0, 0);
    neg; chk("s0_dhs", bus.DHS, 0);
    chk("s0_fa", bus.fwd_sel_a, 0);
    chk("s0_fb", bus.fwd_sel_b, 0);
    chk("s0_cnt", bus.stall_count, 0);
    nxt;

    set_in(1, 1, 3, 0, 0, 1, 0, 1, 0, 0);
    neg; chk("w3_dhs", bus.DHS, 0);
    nxt;
    set_in(1, 0, 0, 0, 3, 0, 0, 1, 0, 0);
    neg; chk("r3a_dhs", bus.DHS, FWD ? 0 : 1);
    chk("r3a_fa", bus.fwd_sel_a, FWD ? 1 : 0);
    nxt;
    neg; chk("r3b_dhs", bus.DHS, FWD ? 0 : 1);
    chk("r3b_fa", bus.fwd_sel_a, FWD ? 2 : 0);
    nxt;
    neg; chk("r3c_dhs", bus.DHS, FWD ? 0 : 1);
    chk("r3c_fa", bus.fwd_sel_a, FWD ? 3 : 0);
    nxt;
    neg; chk("r3d_dhs", bus.DHS, 0);
    chk("r3d_fa", bus.fwd_sel_a, 0);
    chk("r3d_cnt", bus.stall_count, FWD ? 0 : 3);
    nxt;

    set_in(1, 1, 5, 1, 0, 1, 0, 0, 0, 0);
    neg; chk("ld5_dhs", bus.DHS, 0);
    nxt;
    set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    neg; chk("lu_a_dhs", bus.DHS, 1);
    chk("lu_a_fb", bus.fwd_sel_b, 0);
    nxt;
    neg; chk("lu_b_dhs", bus.DHS, FWD ? 0 : 1);
    chk("lu_b_fb", bus.fwd_sel_b, FWD ? 2 : 0);
    nxt;
    neg; chk("lu_c_dhs", bus.DHS, FWD ? 0 : 1);
    chk("lu_c_fb", bus.fwd_sel_b, FWD ? 3 : 0);
    nxt;
    neg; chk("lu_d_dhs", bus.DHS, 0);
    chk("lu_d_fb", bus.fwd_sel_b, 0);
    chk("lu_d_cnt", bus.stall_count, FWD ? 1 : 6);
    nxt;

    set_in(1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    nxt;
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    neg; chk("r0_dhs", bus.DHS, 0);
    chk("r0_fa", bus.fwd_sel_a, 0);
    nxt;
    set_in(1, 1, 2, 0, 0, 1, 0, 1, 0, 0);
    nxt;
    set_in(1, 0, 0, 0, 2, 1, 0, 1, 0, 0);
    neg; chk("ma_dhs", bus.DHS, 0);
    chk("ma_fa", bus.fwd_sel_a, 0);
    nxt;

    set_in(1, 1, 4, 0, 0, 1, 0, 1, 0, 0);
    nxt;
    nxt;
    set_in(1, 0, 0, 0, 4, 0, 4, 0, 0, 0);
    neg; chk("yw_dhs", bus.DHS, FWD ? 0 : 1);
    chk("yw_fa", bus.fwd_sel_a, FWD ? 1 : 0);
    chk("yw_fb", bus.fwd_sel_b, FWD ? 1 : 0);
    nxt;
    neg; chk("yw2_fa", bus.fwd_sel_a, FWD ? 2 : 0);
    nxt;
    neg; chk("yw3_fb", bus.fwd_sel_b, FWD ? 3 : 0);
    nxt;
    neg; chk("yw4_dhs", bus.DHS, 0);
    chk("yw4_cnt", bus.stall_count, FWD ? 1 : 9);
    nxt;

    set_in(1, 1, 6, 0, 0, 1, 0, 1, 1, 0);
    nxt;
    set_in(1, 0, 0, 0, 6, 0, 0, 1, 0, 0);
    neg; chk("fl_dhs", bus.DHS, 0);
    chk("fl_fa", bus.fwd_sel_a, 0);
    nxt;

    set_in(1, 1, 7, 1, 0, 1, 0, 1, 0, 0);
    nxt;
    set_in(1, 0, 0, 0, 7, 0, 0, 1, 0, 1);
    neg; chk("clr_dhs", bus.DHS, 1);
    nxt;
    set_in(1, 0, 0, 0, 7, 0, 0, 1, 0, 0);
    neg; chk("clr_cnt", bus.stall_count, 0);
    chk("clr_dhs2", bus.DHS, FWD ? 0 : 1);
    chk("clr_fa2", bus.fwd_sel_a, FWD ? 2 : 0);
    nxt;
    nxt;
    neg; chk("clr_dhs4", bus.DHS, 0);
    chk("clr_cnt4", bus.stall_count, FWD ? 0 : 2);
    nxt;

    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 1, 1, 0, 1, 0, 1, 0, 0);
      nxt;
      set_in(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      neg; chk("sat_dhs", bus.DHS, 1);
      nxt;
      nxt;
      nxt;
      if (i == 15) begin
        set_in(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        neg; chk("sat_cnt", bus.stall_count, 15);
        nxt;
      end
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    neg; chk("sat_hold", bus.stall_count, 15);
    nxt;
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    nxt;
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    neg; chk("sat_clr", bus.stall_count, 0);
    chk("end_dhs", bus.DHS, 0);
    nxt;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
